// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and the data-port memory.
package lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DATA_START = 32'hC000_0000;
  localparam logic [XLEN-1:0] DATA_SIZE  = 32'h0001_0000;
  localparam logic [XLEN-1:0] CODE_START = 32'h8000_0000;
  localparam int TIMEOUT = 64;

  typedef enum logic [3:0] {
    W_BYTE = 4'd0,
    W_HALF = 4'd1,
    W_WORD = 4'd2
  } width_e;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESPOND
  } lsu_state_e;

  typedef enum logic [2:0] {
    C_NONE      = 3'd0,
    C_LD_MISAL  = 3'd1,
    C_LD_ACCESS = 3'd2,
    C_ST_MISAL  = 3'd3,
    C_ST_ACCESS = 3'd4,
    C_TIMEOUT   = 3'd5,
    C_ILLEGAL   = 3'd6
  } lsu_cause_e;

  typedef struct packed {
    logic            store;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_op_t;

  // funct3[1:0] selects the access size for both loads and stores
  function automatic width_e f3_width(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return W_BYTE;
      2'b01:   return W_HALF;
      default: return W_WORD;
    endcase
  endfunction

  // Fault classification at accept time; illegal beats misaligned beats access
  function automatic lsu_cause_e check_op(input logic store, input logic [2:0] f3,
                                          input logic [XLEN-1:0] ea);
    logic            legal, misal;
    logic [XLEN-1:0] off, nbytes;
    lsu_cause_e      c;
    legal  = (f3[1:0] != 2'b11) && (store ? !f3[2] : !(f3[2] && f3[1]));
    misal  = (f3[1:0] == 2'b01 && ea[0]) || (f3[1:0] == 2'b10 && ea[1:0] != 2'b00);
    nbytes = XLEN'(1) << f3[1:0];
    off    = ea - DATA_START;
    // off >= DATA_SIZE also catches addresses below DATA_START (wraps high)
    if (!legal)                                          c = C_ILLEGAL;
    else if (misal)                                      c = store ? C_ST_MISAL : C_LD_MISAL;
    else if (off >= DATA_SIZE || off + nbytes > DATA_SIZE) c = store ? C_ST_ACCESS : C_LD_ACCESS;
    else                                                 c = C_NONE;
    return c;
  endfunction
endpackage

// File: rtl/lsu_extend.sv
// Load data extension: right-justified memory data to a 32-bit register value.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext
);
  // LB/LH sign-extend, LBU/LHU zero-extend, LW passes through
  always_comb begin
    ext = raw;
    case (funct3)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  ext = {24'h0, raw[7:0]};
      3'b101:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the data port of memory.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [11:0]     req_imm,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [2:0]      resp_cause,
  output logic [XLEN-1:0] resp_addr,
  output logic [XLEN-1:0] address_main,
  output logic [3:0]      width,
  output logic            read_request_main,
  output logic            write_request_main,
  output logic [XLEN-1:0] write_data_main,
  input  logic [XLEN-1:0] data_main,
  input  logic            busy_main
);
  localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

  lsu_state_e      state, state_nx;
  lsu_op_t         op_q;
  lsu_cause_e      cause_q, acc_cause;
  logic [XLEN-1:0] rdata_q, ea, ext;
  logic [6:0]      cnt_q;
  logic            accept, issue;

  assign ea        = req_base + {{(XLEN-12){req_imm[11]}}, req_imm};
  assign acc_cause = check_op(req_store, req_funct3, ea);
  assign req_ready = (state == S_IDLE) && !busy_main;
  assign accept    = req_valid && req_ready;
  // never pulse a request into a busy memory
  assign issue     = (state == S_ISSUE) && !busy_main;

  lsu_extend u_ext (.funct3(op_q.funct3), .raw(data_main), .ext(ext));

  // next-state: faults skip the memory, timeout only while waiting for busy to rise
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (accept) state_nx = (acc_cause == C_NONE) ? S_ISSUE : S_RESPOND;
      S_ISSUE:     if (issue) state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: if (busy_main) state_nx = S_WAIT_DONE;
                   else if (cnt_q == CNT_LAST) state_nx = S_RESPOND;
      S_WAIT_DONE: if (!busy_main) state_nx = S_RESPOND;
      S_RESPOND:   state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // state, latched operation, timeout counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      cause_q <= C_NONE;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (accept) begin
          op_q.store  <= req_store;
          op_q.funct3 <= req_funct3;
          op_q.addr   <= ea;
          op_q.wdata  <= req_store ? req_wdata : '0;
          cause_q     <= acc_cause;
          rdata_q     <= '0;
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT_BUSY: if (!busy_main) begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == CNT_LAST) cause_q <= C_TIMEOUT;
        end
        S_WAIT_DONE: if (!busy_main && !op_q.store) rdata_q <= ext;
        default: ;
      endcase
    end
  end

  assign read_request_main  = issue && !op_q.store;
  assign write_request_main = issue && op_q.store;
  assign address_main       = op_q.addr;
  assign width              = f3_width(op_q.funct3);
  assign write_data_main    = op_q.wdata;

  assign resp_valid = (state == S_RESPOND);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_cause = resp_valid ? cause_q : C_NONE;
  assign resp_addr  = resp_valid ? op_q.addr : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a serializing memory responder.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0, req_wdata = '0;
  logic [11:0] req_imm = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata, resp_addr, address_main, write_data_main;
  logic [2:0]  resp_cause;
  logic [3:0]  width;
  logic        read_request_main, write_request_main;
  logic [31:0] data_main = '0;
  logic        busy_main = 1'b0;

  int n_checks = 0, n_fail = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_imm(req_imm), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_cause(resp_cause), .resp_addr(resp_addr),
    .address_main(address_main), .width(width),
    .read_request_main(read_request_main), .write_request_main(write_request_main),
    .write_data_main(write_data_main), .data_main(data_main), .busy_main(busy_main)
  );

  always #5 clk = ~clk;

  // memory responder: busy for 2/3/5 cycles by width, data valid as busy falls
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int          mem_cnt = 0;
  bit          mem_dead = 1'b0;
  logic [31:0] mem_rd = '0;

  function automatic logic [31:0] mem_read(input logic [15:0] a, input int nb);
    logic [31:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mem[16'(a + i)];
    return v;
  endfunction

  always @(posedge clk) begin
    if (busy_main) begin
      if (mem_cnt == 1) begin
        busy_main <= 1'b0;
        data_main <= mem_rd;
      end
      mem_cnt <= mem_cnt - 1;
    end else if (!mem_dead && (read_request_main || write_request_main)) begin
      busy_main <= 1'b1;
      mem_cnt   <= (width == 4'd0) ? 2 : (width == 4'd1) ? 3 : 5;
      if (write_request_main)
        for (int i = 0; i < (1 << width); i++)
          mem[16'(address_main[15:0] + i)] <= write_data_main[8*i +: 8];
      else
        mem_rd <= mem_read(address_main[15:0], 1 << width);
    end
  end

  // protocol monitors
  int npulse = 0, resp_cnt = 0, busy_viol = 0, acc_cnt = 0;
  logic [3:0] last_w = '0;
  always @(negedge clk) begin
    if (read_request_main || write_request_main) begin
      npulse++;
      last_w = width;
      if (busy_main) busy_viol++;
    end
    if (resp_valid) resp_cnt++;
  end
  always @(posedge clk) if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;

  // reference: architectural effect of one op on a byte-array data RAM
  task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] base,
                       input bit [11:0] imm, input bit [31:0] wd,
                       output bit [2:0] c, output bit [31:0] rd, output bit [31:0] ea);
    int simm, sz, off;
    longint v;
    bit legal;
    simm  = $signed(imm);
    ea    = base + simm;
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rd    = '0;
    if (!legal) c = 3'd6;
    else if (ea % sz != 0) c = st ? 3'd3 : 3'd1;
    else if (ea < 32'hC000_0000 || longint'(ea) + sz > 64'hC001_0000) c = st ? 3'd4 : 3'd2;
    else begin
      c   = 3'd0;
      off = ea - 32'hC000_0000;
      if (st) for (int i = 0; i < sz; i++) ref_mem[off + i] = wd[8*i +: 8];
      else begin
        v = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_mem[off + i]) << (8 * i);
        if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
          v -= longint'(1) << (8 * sz);
        rd = v[31:0];
      end
    end
  endtask

  // drive one op, wait for its response; k = cycles from accept edge (-1 on no response)
  task automatic do_op(input bit st, input bit [2:0] f3, input bit [31:0] base,
                       input bit [11:0] imm, input bit [31:0] wd,
                       output bit [2:0] c, output bit [31:0] rd, output bit [31:0] a,
                       output int k, output int np, output bit [3:0] pw);
    int w = 0, p0;
    @(negedge clk);
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_base = base; req_imm = imm; req_wdata = wd;
    p0 = npulse;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1; c = 3'h7; rd = '0; a = '0;
    while (!resp_valid && k < 200) begin @(negedge clk); k++; end
    if (!resp_valid) k = -1;
    else begin c = resp_cause; rd = resp_rdata; a = resp_addr; end
    np = npulse - p0;
    pw = last_w;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({resp_valid, read_request_main, write_request_main} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b exp 000", {resp_valid, read_request_main, write_request_main});
    end
    n_checks++;
    if ({address_main, width, write_data_main} !== 68'h0) begin
      n_fail++; $display("FAIL reset_mem_side: got addr %h w %h wd %h exp 0", address_main, width, write_data_main);
    end
    n_checks++;
    if ({resp_rdata, resp_cause, resp_addr} !== 67'h0) begin
      n_fail++; $display("FAIL reset_resp: got %h %h %h exp 0", resp_rdata, resp_cause, resp_addr);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    bit [2:0] c, ec; bit [31:0] rd, a, erd, ea; int k, np; bit [3:0] pw;
    model(1, 3'd2, 32'hC000_0000, 12'd8, 32'hDEAD_BEEF, ec, erd, ea);
    do_op(1, 3'd2, 32'hC000_0000, 12'd8, 32'hDEAD_BEEF, c, rd, a, k, np, pw);
    n_checks++;
    if ({c, rd, a, np} !== {3'd0, 32'h0, 32'hC000_0008, 32'd1}) begin
      n_fail++; $display("FAIL sw: got c%0d rd %h a %h np %0d exp c0 rd 0 a c0000008 np 1", c, rd, a, np);
    end
    model(0, 3'd2, 32'hC000_0000, 12'd8, 32'h0, ec, erd, ea);
    do_op(0, 3'd2, 32'hC000_0000, 12'd8, 32'h0, c, rd, a, k, np, pw);
    n_checks++;
    if ({c, rd, a} !== {3'd0, 32'hDEAD_BEEF, 32'hC000_0008}) begin
      n_fail++; $display("FAIL lw_data: got c%0d rd %h a %h exp c0 rd deadbeef a c0000008", c, rd, a);
    end
    n_checks++;
    if (np !== 1 || pw !== 4'd2 || k !== 8) begin
      n_fail++; $display("FAIL lw_timing: got np %0d w %0d lat %0d exp np 1 w 2 lat 8", np, pw, k);
    end
  endtask

  task automatic test_extend;
    bit          st [6] = '{1, 0, 0, 1, 0, 0};
    bit [2:0]    f3 [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd5};
    bit [31:0]   ad [6] = '{32'hC000_0003, 32'hC000_0003, 32'hC000_0003,
                            32'hC000_0010, 32'hC000_0010, 32'hC000_0010};
    bit [31:0]   wd [6] = '{32'h1234_5680, 0, 0, 32'hAAAA_8001, 0, 0};
    bit [31:0]   ex [6] = '{0, 32'hFFFF_FF80, 32'h0000_0080, 0, 32'hFFFF_8001, 32'h0000_8001};
    int          lt [6] = '{5, 5, 5, 6, 6, 6};
    bit [2:0] c, ec; bit [31:0] rd, a, erd, ea; int k, np; bit [3:0] pw;
    for (int i = 0; i < 6; i++) begin
      model(st[i], f3[i], ad[i], 12'd0, wd[i], ec, erd, ea);
      do_op(st[i], f3[i], ad[i], 12'd0, wd[i], c, rd, a, k, np, pw);
      n_checks++;
      if ({c, rd, a, k} !== {3'd0, ex[i], ad[i], lt[i]}) begin
        n_fail++; $display("FAIL extend[%0d]: got c%0d rd %h a %h lat %0d exp c0 rd %h a %h lat %0d",
                           i, c, rd, a, k, ex[i], ad[i], lt[i]);
      end
    end
  endtask

  task automatic test_faults;
    bit        st [9] = '{0, 1, 0, 1, 0, 0, 0, 1, 0};
    bit [2:0]  f3 [9] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd2, 3'd2, 3'd1, 3'd2, 3'd7};
    bit [31:0] bs [9] = '{32'hC000_0002, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000,
                          32'hC000_FFFC, 32'hC001_0000, 32'hC000_0010, 32'hC000_0001, 32'hC000_0001};
    bit [11:0] im [9] = '{0, 0, 0, 0, 0, 0, 12'hFF0, 0, 0};
    bit [2:0]  ec [9] = '{3'd1, 3'd4, 3'd6, 3'd6, 3'd0, 3'd2, 3'd0, 3'd3, 3'd6};
    bit [31:0] ea [9] = '{32'hC000_0002, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000,
                          32'hC000_FFFC, 32'hC001_0000, 32'hC000_0000, 32'hC000_0001, 32'hC000_0001};
    bit [2:0] c, mc; bit [31:0] rd, a, mrd, mea; int k, np, ek, enp; bit [3:0] pw;
    for (int i = 0; i < 9; i++) begin
      model(st[i], f3[i], bs[i], im[i], 32'h5555_AAAA, mc, mrd, mea);
      do_op(st[i], f3[i], bs[i], im[i], 32'h5555_AAAA, c, rd, a, k, np, pw);
      ek  = (ec[i] != 0) ? 1 : (f3[i][1:0] == 2'd2 ? 8 : 6);
      enp = (ec[i] != 0) ? 0 : 1;
      n_checks++;
      if ({c, a, rd} !== {ec[i], ea[i], mrd} || k !== ek || np !== enp) begin
        n_fail++; $display("FAIL fault[%0d]: got c%0d a %h rd %h lat %0d np %0d exp c%0d a %h rd %h lat %0d np %0d",
                           i, c, a, rd, k, np, ec[i], ea[i], mrd, ek, enp);
      end
    end
  endtask

  task automatic test_timeout;
    bit [2:0] c; bit [31:0] rd, a; int k, np; bit [3:0] pw;
    mem_dead = 1'b1;
    do_op(0, 3'd2, 32'hC000_0000, 12'd0, 32'h0, c, rd, a, k, np, pw);
    mem_dead = 1'b0;
    n_checks++;
    if ({c, rd, a} !== {3'd5, 32'h0, 32'hC000_0000}) begin
      n_fail++; $display("FAIL timeout_resp: got c%0d rd %h a %h exp c5 rd 0 a c0000000", c, rd, a);
    end
    n_checks++;
    if (k !== 66 || np !== 1) begin
      n_fail++; $display("FAIL timeout_lat: got lat %0d np %0d exp lat 66 np 1", k, np);
    end
  endtask

  task automatic test_reset_midflight;
    bit [2:0] c, ec; bit [31:0] rd, a, erd, ea; int k, np, w, bad, r0; bit [3:0] pw;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
    req_base = 32'hC000_0008; req_imm = 12'd0;
    r0 = resp_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!busy_main && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0; w = 0;
    while (busy_main && w < 50) begin
      if (req_ready !== 1'b0) bad++;
      @(negedge clk); w++;
    end
    @(negedge clk);
    n_checks++;
    if (bad !== 0 || w >= 50) begin
      n_fail++; $display("FAIL rst_ready_blocked: got %0d ready-while-busy cycles (wait %0d) exp 0", bad, w);
    end
    n_checks++;
    if (resp_cnt - r0 !== 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_drop: got %0d responses ready %b exp 0 responses ready 1", resp_cnt - r0, req_ready);
    end
    model(0, 3'd2, 32'hC000_0008, 12'd0, 32'h0, ec, erd, ea);
    do_op(0, 3'd2, 32'hC000_0008, 12'd0, 32'h0, c, rd, a, k, np, pw);
    n_checks++;
    if ({c, rd, a, k} !== {3'd0, 32'hDEAD_BEEF, 32'hC000_0008, 8}) begin
      n_fail++; $display("FAIL rst_next_lw: got c%0d rd %h a %h lat %0d exp c0 rd deadbeef a c0000008 lat 8", c, rd, a, k);
    end
  endtask

  task automatic test_held_valid;
    int a0, r0, w;
    bit [31:0] rd;
    @(negedge clk);
    a0 = acc_cnt; r0 = resp_cnt;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
    req_base = 32'hC000_0004; req_imm = 12'd4;
    w = 0;
    do begin @(negedge clk); w++; end while (!resp_valid && w < 50);
    rd = resp_rdata;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (acc_cnt - a0 !== 1 || resp_cnt - r0 !== 1 || rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL held_valid: got %0d accepts %0d responses rd %h exp 1 1 deadbeef",
                         acc_cnt - a0, resp_cnt - r0, rd);
    end
  endtask

  task automatic test_random;
    bit [31:0] far [4] = '{32'h8000_0000, 32'hC000_FFF0, 32'hC001_0000, 32'hBFFF_FFF8};
    bit [2:0]  lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit st; bit [2:0] f3, c, ec; bit [31:0] base, wd, rd, a, erd, ea; bit [11:0] imm;
    int k, np; bit [3:0] pw;
    for (int n = 0; n < 40; n++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      base = ($urandom_range(0, 7) == 0) ? far[$urandom_range(0, 3)]
                                         : 32'hC000_0100 + $urandom_range(0, 255);
      imm  = 12'($urandom_range(0, 127)) - 12'd64;
      wd   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        f3   = st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
        base = base & ~32'h3;
        imm  = imm & 12'hFFC;
      end
      model(st, f3, base, imm, wd, ec, erd, ea);
      do_op(st, f3, base, imm, wd, c, rd, a, k, np, pw);
      n_checks++;
      if ({c, rd, a} !== {ec, erd, ea} || np !== ((ec == 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL rand[%0d] st%0d f3=%0d: got c%0d rd %h a %h np %0d exp c%0d rd %h a %h",
                           n, st, f3, c, rd, a, np, ec, erd, ea);
      end
    end
  endtask

  task automatic test_protocol;
    n_checks++;
    if (busy_viol !== 0) begin
      n_fail++; $display("FAIL req_while_busy: got %0d exp 0", busy_viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h0; ref_mem[i] = 8'h0; end
    test_reset();
    test_word();
    test_extend();
    test_faults();
    test_timeout();
    test_reset_midflight();
    test_held_valid();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data port of the `memory` block. It accepts one load or store at a time from the execute stage, computes and checks the effective address, and drives the `address_main`/`width`/`read_request_main`/`write_request_main`/`write_data_main` request interface. It then tracks `busy_main` until completion, sign- or zero-extends load data, and returns a single-cycle response with fault reporting to writeback.

## Interface
- `DATA_START`, 32'hC000_0000, base of data RAM
- `DATA_SIZE`, 32'h0001_0000, bytes of data RAM (16-bit byte address inside memory)
- `TIMEOUT`, 64, max cycles waiting for `busy_main` to rise after a request pulse

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  core presents an operation
- `req_ready`  out  1  LSU can accept; transfer on `req_valid && req_ready`
- `req_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- `req_base`  in  32  rs1 value
- `req_imm`  in  12  signed offset
- `req_wdata`  in  32  rs2 value (store data, low bytes used)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data (0 for stores/faults)
- `resp_cause`  out  3  0 none, 1 load misaligned, 2 load access, 3 store misaligned, 4 store access, 5 timeout, 6 illegal funct3
- `resp_addr`  out  32  effective address (for mtval)
- `address_main`  out  32  to memory
- `width`  out  4  Width encoding: BYTE 0, HALFWORD 1, WORD 2
- `read_request_main`  out  1  load request pulse
- `write_request_main`  out  1  store request pulse
- `write_data_main`  out  32  store data
- `data_main`  in  32  load data, little-endian, valid when `busy_main` falls
- `busy_main`  in  1  memory busy

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE: `req_ready = !busy_main`. On accept, latch op. EA = `req_base + sext(req_imm)`, mod 2^32.
- Accept checks, in priority order:
  - Illegal funct3 (load 011/110/111; store other than 000–010) → cause 6.
  - Misalignment (half with EA[0]≠0, word with EA[1:0]≠0) → cause 1/3.
  - EA outside [DATA_START, DATA_START+DATA_SIZE), or access end crossing the top → cause 2/4.
- Faulted accept → RESPOND; no memory request is issued. Otherwise → ISSUE.
- ISSUE: assert exactly one request line for one cycle. Hold `address_main`/`width`/`write_data_main` stable from ISSUE through RESPOND. → WAIT_BUSY, clear timeout counter.
- WAIT_BUSY: `busy_main` = 1 → WAIT_DONE. Counter reaching TIMEOUT → RESPOND with cause 5.
- WAIT_DONE: `busy_main` = 0 → capture `data_main`, extend per funct3 (LB/LH sign, LBU/LHU zero, LW as-is) → RESPOND.
- RESPOND: `resp_valid` = 1 for one cycle → IDLE.
- Reset: state IDLE. All outputs 0 except `req_ready`, which is `!busy_main`. Any in-flight op is dropped with no response. A memory still busy from before reset blocks acceptance until it goes idle.

## Timing
- Accept at edge N. Request pulse in cycle N+1. Memory asserts busy in N+2.
- Fault response: `resp_valid` in cycle N+1.
- Load latency: byte 2 memory cycles, half 3, word 5 (memory serializes bytes). Response one cycle after `busy_main` falls.
- `req_ready` is 0 from accept until the cycle after RESPOND. No back-to-back overlap.
- Request lines are never high while `busy_main` is high.

## Structure
- Package `lsu_pkg`:
  - `XLEN`, `DATA_START`, `CODE_START`
  - Width enum (shared with `memory`)
  - LsuState enum
  - LsuCause enum
- Sub-module `lsu_extend`: combinational funct3 + raw data → extended result.
- Target 150–250 lines.

## Test plan
- LW at base C000_0000 + imm 8 after SW of DEAD_BEEF there → `resp_rdata` DEAD_BEEF, cause 0, one read pulse with width 2.
- LB/LBU of byte 0x80 at C000_0003 → FFFF_FF80 / 0000_0080; LH/LHU of 0x8001 → FFFF_8001 / 0000_8001.
- LW at C000_0002 → cause 1, `resp_addr` C000_0002, `resp_valid` one cycle after accept, no request pulse. SH at 8000_0000 → cause 4.
- Memory model holds `busy_main` low forever → cause 5 exactly TIMEOUT+2 cycles after accept.
- `rst` asserted in WAIT_DONE while memory busy → no `resp_valid`, `req_ready` stays 0 until `busy_main` falls, then next LW completes correctly.
- funct3 011 load → cause 6. `req_valid` held through a 5-cycle word op → exactly one accept and one response.
